// File: rtl/relu_pool_wb_pkg.sv
// relu_pool_wb_pkg -- shared types and helpers for the ReLU / 2x2 max-pool /
// word-pack writeback stage.
//
// Contents:
//   DATA_W, LANES, WORD_W : value width, lanes per packed word, packed width
//   sample_t, lane_t      : signed value type and lane index type
//   lane_msb(k)           : MSB of lane k in a packed word (lane 0 at the top)
//   smax(a, b)            : signed maximum
//   relu(x)               : clamp negatives to zero
//   sat_add(a, b)         : signed add clamped to the sample_t range
package relu_pool_wb_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int WORD_W = LANES * DATA_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [1:0]               lane_t;

  localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(DATA_W-1){1'b0}}});

  // Lane k occupies bits [(LANES-k)*DATA_W-1 -: DATA_W]; lane 0 is the MSB lane.
  function automatic int lane_msb(input int k);
    return (LANES - k) * DATA_W - 1;
  endfunction

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic sample_t relu(input sample_t x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  // Add in DATA_W+1 bits; the two top bits disagree exactly on overflow, and
  // the extra bit then tells which rail to clamp to.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/relu_pool_wb_line_buf.sv
// pool_line_buf -- holds the horizontal pair maxima of an even row until the
// matching odd row arrives.
//
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_idx   in  write entry (column pair index)
//   wr_data  in  value written
//   rd_idx   in  read entry
//   rd_data  out combinational read of entry rd_idx
//
// Contents are intentionally not reset: every entry is rewritten by the even
// row before the odd row reads it.
module pool_line_buf #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/relu_pool_wb.sv
// relu_pool_wb -- takes finished neuron sums in raster order, applies ReLU and
// 2x2 stride-2 max pooling, packs four pooled values per word (lane 0 in the
// top DATA_W bits) and writes the words to the next layer's ifm buffer.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   in_valid    in_data carries a neuron sum this cycle (no backpressure)
//   in_data     signed neuron sum
//   bias        signed per-plane bias (used only with RELU_POOL_BIAS_EN)
//   out_we      one-cycle write strobe, registered
//   out_addr    write address; advances by one after each write, wraps
//   out_data    packed pooled word; unused lanes of a short word are zero
//   plane_done  pulses with the write of the last word of a plane
//   busy        high while a plane is partially received
//
// Build option: RELU_POOL_BIAS_EN -- when defined, each sample is replaced by
// the saturated sum in_data + bias before ReLU.
//
// DATA_W must match relu_pool_wb_pkg::DATA_W (the helpers are typed on it).
module relu_pool_wb #(
  parameter int              DATA_W    = relu_pool_wb_pkg::DATA_W,
  parameter int              COLS      = 8,
  parameter int              ROWS      = 8,
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]   bias,
  output logic                out_we,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [4*DATA_W-1:0] out_data,
  output logic                plane_done,
  output logic                busy
);

  import relu_pool_wb_pkg::*;

  localparam int PACK_W   = 4 * DATA_W;
  localparam int LB_DEPTH = COLS / 2;
  localparam int LB_IDX_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int COL_W    = $clog2(COLS);
  localparam int ROW_W    = $clog2(ROWS);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam lane_t            LANE_LAST = lane_t'(LANES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  lane_t             lane_q, lane_d;
  sample_t           pair_q, pair_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic              busy_q, busy_d;
  logic              out_we_q, out_we_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [PACK_W-1:0] out_data_q, out_data_d;
  logic              plane_done_q, plane_done_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  sample_t             x_val;
  sample_t             r_val;
  sample_t             hmax;
  sample_t             pooled;
  logic [DATA_W-1:0]   lb_rd;
  logic                lb_we;
  logic [LB_IDX_W-1:0] lb_idx;
  logic                col_end;
  logic                row_end;
  logic [PACK_W-1:0]   word;

`ifdef RELU_POOL_BIAS_EN
  always_comb begin
    x_val = sat_add(sample_t'(in_data), sample_t'(bias));
  end
`else
  logic unused_bias;
  assign unused_bias = ^bias;

  always_comb begin
    x_val = sample_t'(in_data);
  end
`endif

  always_comb begin
    r_val  = relu(x_val);
    hmax   = smax(pair_q, r_val);
    pooled = smax(sample_t'(lb_rd), hmax);
  end

  assign col_end = (col_q == COL_LAST);
  assign row_end = (row_q == ROW_LAST);
  // Column pair index doubles as the line buffer entry for both rows.
  assign lb_idx  = LB_IDX_W'(col_q >> 1);

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_DEPTH)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_idx  (lb_idx),
    .wr_data (hmax),
    .rd_idx  (lb_idx),
    .rd_data (lb_rd)
  );

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    lane_d       = lane_q;
    pair_d       = pair_q;
    pack_d       = pack_q;
    busy_d       = busy_q;
    out_we_d     = 1'b0;
    // Writes are never on consecutive cycles, so advancing the address in the
    // cycle after a strobe keeps out_addr pointing at the next free entry.
    out_addr_d   = out_we_q ? (out_addr_q + ADDR_W'(1)) : out_addr_q;
    out_data_d   = out_data_q;
    plane_done_d = 1'b0;
    lb_we        = 1'b0;
    word         = pack_q;

    if (in_valid) begin
      col_d  = col_end ? '0 : (col_q + COL_W'(1));
      if (col_end) begin
        row_d = row_end ? '0 : (row_q + ROW_W'(1));
      end
      busy_d = !(col_end && row_end);

      if (!col_q[0]) begin
        pair_d = r_val;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_q == lane_t'(k)) begin
            word[lane_msb(k) -: DATA_W] = pooled;
          end
        end
        // Flush on a full word or at the end of the pooled row; the lane
        // counter restarts for every pooled row.
        if ((lane_q == LANE_LAST) || col_end) begin
          out_we_d     = 1'b1;
          out_data_d   = word;
          plane_done_d = col_end && row_end;
          pack_d       = '0;
          lane_d       = '0;
        end else begin
          pack_d = word;
          lane_d = lane_q + lane_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      lane_q       <= '0;
      pair_q       <= '0;
      pack_q       <= '0;
      busy_q       <= 1'b0;
      out_we_q     <= 1'b0;
      out_addr_q   <= BASE_ADDR;
      out_data_q   <= '0;
      plane_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      lane_q       <= lane_d;
      pair_q       <= pair_d;
      pack_q       <= pack_d;
      busy_q       <= busy_d;
      out_we_q     <= out_we_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      plane_done_q <= plane_done_d;
    end
  end

  assign out_we     = out_we_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign plane_done = plane_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_relu_pool_wb.sv
// tb_relu_pool_wb -- directed bench for relu_pool_wb. Two instances share the
// clock and reset: an 8x2 plane (BASE_ADDR 0x0010) and a 4x2 plane
// (BASE_ADDR 0) for the short-word case. Honors RELU_POOL_BIAS_EN.
module tb_relu_pool_wb;

  localparam logic [15:0] BASE8 = 16'h0010;
  localparam logic [15:0] BASE4 = 16'h0000;
  localparam logic [63:0] RAMP_WORD = 64'h0009_000B_000D_000F;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v8 = 1'b0;
  logic [15:0] d8 = '0;
  logic        v4 = 1'b0;
  logic [15:0] d4 = '0;
  logic [15:0] bias = '0;

  logic        we8, pd8, busy8;
  logic [15:0] addr8;
  logic [63:0] data8;
  logic        we4, pd4, busy4;
  logic [15:0] addr4;
  logic [63:0] data4;

  relu_pool_wb #(.DATA_W(16), .COLS(8), .ROWS(2), .ADDR_W(16), .BASE_ADDR(BASE8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .bias(bias),
    .out_we(we8), .out_addr(addr8), .out_data(data8), .plane_done(pd8), .busy(busy8)
  );

  relu_pool_wb #(.DATA_W(16), .COLS(4), .ROWS(2), .ADDR_W(16), .BASE_ADDR(BASE4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .bias(bias),
    .out_we(we4), .out_addr(addr4), .out_data(data4), .plane_done(pd4), .busy(busy4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [15:0] exp_addr_q[$];
  logic [63:0] got_data_q[$];
  logic [15:0] got_addr_q[$];
  int          wr8_cnt = 0;
  int          pd8_cnt = 0;
  logic [15:0] exp_addr8 = BASE8;

  always @(negedge clk) begin
    if (we8) begin
      wr8_cnt = wr8_cnt + 1;
      got_data_q.push_back(data8);
      got_addr_q.push_back(addr8);
    end
    if (pd8) pd8_cnt = pd8_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Drivers: inputs change on the falling edge, DUT samples on the rising edge
  // ---------------------------------------------------------------------------
  task automatic drive8(input logic [15:0] d);
    @(negedge clk);
    v8 = 1'b1;
    d8 = d;
  endtask

  task automatic drive4(input logic [15:0] d);
    @(negedge clk);
    v4 = 1'b1;
    d4 = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v8 = 1'b0;
      v4 = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_vec++; if (we8 !== 1'b0) begin n_err++; $display("FAIL reset_we8: got %b exp 0", we8); end
    n_vec++; if (addr8 !== BASE8) begin n_err++; $display("FAIL reset_addr8: got %h exp %h", addr8, BASE8); end
    n_vec++; if (data8 !== 64'h0) begin n_err++; $display("FAIL reset_data8: got %h exp 0", data8); end
    n_vec++; if (pd8 !== 1'b0) begin n_err++; $display("FAIL reset_pd8: got %b exp 0", pd8); end
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy8: got %b exp 0", busy8); end
    n_vec++; if (we4 !== 1'b0) begin n_err++; $display("FAIL reset_we4: got %b exp 0", we4); end
    n_vec++; if (addr4 !== BASE4) begin n_err++; $display("FAIL reset_addr4: got %h exp %h", addr4, BASE4); end
    n_vec++; if (data4 !== 64'h0) begin n_err++; $display("FAIL reset_data4: got %h exp 0", data4); end
    n_vec++; if (pd4 !== 1'b0) begin n_err++; $display("FAIL reset_pd4: got %b exp 0", pd4); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy4: got %b exp 0", busy4); end
    @(negedge clk);
    rst = 1'b0;
    exp_addr8 = BASE8;
  endtask

  task automatic test_ramp();
    int wr0;
    wr0 = wr8_cnt;
    drive8(16'd0);
    idle(0);
    @(negedge clk);
    d8 = 16'd1;
    n_vec++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL ramp_busy_rise: got %b exp 1", busy8); end
    for (int i = 2; i < 16; i++) drive8(16'(i));
    n_vec++; if (we8 !== 1'b0) begin n_err++; $display("FAIL ramp_early_we: got %b exp 0", we8); end
    idle(1);
    n_vec++; if (we8 !== 1'b1) begin n_err++; $display("FAIL ramp_we: got %b exp 1", we8); end
    n_vec++; if (pd8 !== 1'b1) begin n_err++; $display("FAIL ramp_plane_done: got %b exp 1", pd8); end
    n_vec++; if (addr8 !== exp_addr8) begin n_err++; $display("FAIL ramp_addr: got %h exp %h", addr8, exp_addr8); end
    n_vec++; if (data8 !== RAMP_WORD) begin n_err++; $display("FAIL ramp_data: got %h exp %h", data8, RAMP_WORD); end
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL ramp_busy_fall: got %b exp 0", busy8); end
    idle(1);
    n_vec++; if (we8 !== 1'b0) begin n_err++; $display("FAIL ramp_we_pulse: got %b exp 0", we8); end
    n_vec++; if (addr8 !== exp_addr8 + 16'd1) begin n_err++; $display("FAIL ramp_addr_inc: got %h exp %h", addr8, exp_addr8 + 16'd1); end
    idle(2);
    n_vec++; if (wr8_cnt - wr0 !== 1) begin n_err++; $display("FAIL ramp_write_count: got %0d exp 1", wr8_cnt - wr0); end
    exp_addr8 = exp_addr8 + 16'd1;
  endtask

  task automatic test_relu();
    logic [63:0] exp_w;
    exp_w = 64'h0000_0000_0003_0000;
    for (int i = 0; i < 16; i++) drive8((i == 13) ? 16'h0003 : 16'hFFF0);
    idle(1);
    n_vec++; if (we8 !== 1'b1) begin n_err++; $display("FAIL relu_we: got %b exp 1", we8); end
    n_vec++; if (data8 !== exp_w) begin n_err++; $display("FAIL relu_data: got %h exp %h", data8, exp_w); end
    n_vec++; if (addr8 !== exp_addr8) begin n_err++; $display("FAIL relu_addr: got %h exp %h", addr8, exp_addr8); end
    n_vec++; if (pd8 !== 1'b1) begin n_err++; $display("FAIL relu_plane_done: got %b exp 1", pd8); end
    idle(2);
    exp_addr8 = exp_addr8 + 16'd1;
  endtask

  task automatic test_gaps();
    int wr0, pd0;
    logic [63:0] got_w, exp_w;
    logic [15:0] got_a, exp_a;
    wr0 = wr8_cnt;
    pd0 = pd8_cnt;
    got_data_q.delete();
    got_addr_q.delete();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        drive8(16'(i));
        idle(int'($urandom_range(0, 3)));
      end
      exp_q.push_back(RAMP_WORD);
      exp_addr_q.push_back(exp_addr8);
      exp_addr8 = exp_addr8 + 16'd1;
    end
    idle(3);
    n_vec++; if (wr8_cnt - wr0 !== 2) begin n_err++; $display("FAIL gaps_write_count: got %0d exp 2", wr8_cnt - wr0); end
    n_vec++; if (pd8_cnt - pd0 !== 2) begin n_err++; $display("FAIL gaps_plane_done_count: got %0d exp 2", pd8_cnt - pd0); end
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      exp_a = exp_addr_q.pop_front();
      got_w = (got_data_q.size() > 0) ? got_data_q.pop_front() : 64'hx;
      got_a = (got_addr_q.size() > 0) ? got_addr_q.pop_front() : 16'hx;
      n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL gaps_data: got %h exp %h", got_w, exp_w); end
      n_vec++; if (got_a !== exp_a) begin n_err++; $display("FAIL gaps_addr: got %h exp %h", got_a, exp_a); end
    end
  endtask

  task automatic test_partial();
    logic [63:0] exp_w;
    exp_w = 64'h0005_0007_0000_0000;
    for (int i = 0; i < 8; i++) drive4(16'(i));
    idle(1);
    n_vec++; if (we4 !== 1'b1) begin n_err++; $display("FAIL partial_we: got %b exp 1", we4); end
    n_vec++; if (data4 !== exp_w) begin n_err++; $display("FAIL partial_data: got %h exp %h", data4, exp_w); end
    n_vec++; if (addr4 !== BASE4) begin n_err++; $display("FAIL partial_addr: got %h exp %h", addr4, BASE4); end
    n_vec++; if (pd4 !== 1'b1) begin n_err++; $display("FAIL partial_plane_done: got %b exp 1", pd4); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL partial_busy: got %b exp 0", busy4); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int wr0;
    for (int i = 0; i < 10; i++) drive8(16'(100 + i));
    @(negedge clk);
    v8  = 1'b0;
    rst = 1'b1;
    n_vec++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b exp 1", busy8); end
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_after: got %b exp 0", busy8); end
    n_vec++; if (addr8 !== BASE8) begin n_err++; $display("FAIL rstmid_addr_reset: got %h exp %h", addr8, BASE8); end
    exp_addr8 = BASE8;
    wr0 = wr8_cnt;
    got_data_q.delete();
    got_addr_q.delete();
    for (int i = 0; i < 16; i++) drive8(16'(i));
    idle(3);
    n_vec++; if (wr8_cnt - wr0 !== 1) begin n_err++; $display("FAIL rstmid_write_count: got %0d exp 1", wr8_cnt - wr0); end
    n_vec++; if (got_addr_q.size() == 0 || got_addr_q[0] !== BASE8) begin
      n_err++; $display("FAIL rstmid_addr: got %h exp %h", (got_addr_q.size() > 0) ? got_addr_q[0] : 16'hx, BASE8);
    end
    n_vec++; if (got_data_q.size() == 0 || got_data_q[0] !== RAMP_WORD) begin
      n_err++; $display("FAIL rstmid_data: got %h exp %h", (got_data_q.size() > 0) ? got_data_q[0] : 64'hx, RAMP_WORD);
    end
    exp_addr8 = exp_addr8 + 16'd1;
  endtask

`ifdef RELU_POOL_BIAS_EN
  task automatic test_bias();
    logic [63:0] exp_w;
    bias  = 16'h7000;
    exp_w = 64'h7FFF_7FFF_7FFF_7FFF;
    for (int i = 0; i < 16; i++) drive8(16'h2000);
    idle(1);
    n_vec++; if (we8 !== 1'b1) begin n_err++; $display("FAIL bias_sat_we: got %b exp 1", we8); end
    n_vec++; if (data8 !== exp_w) begin n_err++; $display("FAIL bias_sat_data: got %h exp %h", data8, exp_w); end
    idle(1);
    exp_addr8 = exp_addr8 + 16'd1;
    bias  = 16'hF000;
    exp_w = 64'h0;
    for (int i = 0; i < 16; i++) drive8(16'h0800);
    idle(1);
    n_vec++; if (we8 !== 1'b1) begin n_err++; $display("FAIL bias_neg_we: got %b exp 1", we8); end
    n_vec++; if (data8 !== exp_w) begin n_err++; $display("FAIL bias_neg_data: got %h exp %h", data8, exp_w); end
    n_vec++; if (addr8 !== exp_addr8) begin n_err++; $display("FAIL bias_neg_addr: got %h exp %h", addr8, exp_addr8); end
    idle(1);
    exp_addr8 = exp_addr8 + 16'd1;
    bias = 16'h0000;
  endtask
`else
  task automatic test_bias();
    bias = 16'h7000;
    for (int i = 0; i < 16; i++) drive8(16'(i));
    idle(1);
    n_vec++; if (we8 !== 1'b1) begin n_err++; $display("FAIL bias_ignored_we: got %b exp 1", we8); end
    n_vec++; if (data8 !== RAMP_WORD) begin n_err++; $display("FAIL bias_ignored_data: got %h exp %h", data8, RAMP_WORD); end
    n_vec++; if (addr8 !== exp_addr8) begin n_err++; $display("FAIL bias_ignored_addr: got %h exp %h", addr8, exp_addr8); end
    idle(1);
    exp_addr8 = exp_addr8 + 16'd1;
    bias = 16'h0000;
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_ramp();
    test_relu();
    test_gaps();
    test_partial();
    test_reset_mid();
    test_bias();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
